// File: rtl/harness_serial_driver.sv
// Host-side driver for the two-pin synthesis test harness: serializes a command word
// MSB-first toward test_i, waits a fixed gap, then deserializes the response from test_o.
module harness_serial_driver #(
    parameter int TX_WIDTH   = 166,
    parameter int RX_WIDTH   = 327,
    parameter int GAP_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                abort,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [TX_WIDTH-1:0] req_word,
    output logic                bit_out,
    output logic                bit_out_valid,
    input  logic                bit_in,
    output logic                rsp_valid,
    output logic [RX_WIDTH-1:0] rsp_word,
    output logic                busy
);

    localparam int MAX_TR = (TX_WIDTH > RX_WIDTH) ? TX_WIDTH : RX_WIDTH;
    localparam int MAX_CN = (MAX_TR > GAP_CYCLES) ? MAX_TR : GAP_CYCLES;
    localparam int CW     = $clog2(MAX_CN + 1);

    localparam logic [CW-1:0] TX_LAST  = CW'(TX_WIDTH - 1);
    localparam logic [CW-1:0] RX_LAST  = CW'(RX_WIDTH - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_TX   = 3'd1,
        S_GAP  = 3'd2,
        S_RX   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    // With no gap the TX phase hands over straight to sampling.
    localparam state_t AFTER_TX = (GAP_CYCLES == 0) ? S_RX : S_GAP;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [TX_WIDTH-1:0]   tx_sr_q, tx_sr_d;
    logic [RX_WIDTH-1:0]   rx_sr_q, rx_sr_d;
    logic                  bit_out_q, bit_out_d;
    logic                  bit_out_valid_q, bit_out_valid_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [RX_WIDTH-1:0]   rsp_word_q, rsp_word_d;

    // Next-state and registered-output logic.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        tx_sr_d         = tx_sr_q;
        rx_sr_d         = rx_sr_q;
        bit_out_d       = 1'b0;
        bit_out_valid_d = 1'b0;
        rsp_valid_d     = 1'b0;
        rsp_word_d      = rsp_word_q;
        if (abort) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            tx_sr_d = '0;
            rx_sr_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        tx_sr_d         = {req_word[TX_WIDTH-2:0], 1'b0};
                        bit_out_d       = req_word[TX_WIDTH-1];
                        bit_out_valid_d = 1'b1;
                        cnt_d           = '0;
                        state_d         = S_TX;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_TX: begin
                    // cnt counts bits already on the wire; the MSB went out on acceptance.
                    if (cnt_q == TX_LAST) begin
                        cnt_d   = '0;
                        tx_sr_d = '0;
                        state_d = AFTER_TX;
                    end else begin
                        cnt_d           = cnt_q + CW'(1);
                        bit_out_d       = tx_sr_q[TX_WIDTH-1];
                        bit_out_valid_d = 1'b1;
                        tx_sr_d         = {tx_sr_q[TX_WIDTH-2:0], 1'b0};
                    end
                end
                S_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_d   = '0;
                        state_d = S_RX;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_RX: begin
                    rx_sr_d = {rx_sr_q[RX_WIDTH-2:0], bit_in};
                    if (cnt_q == RX_LAST) begin
                        rsp_word_d  = {rx_sr_q[RX_WIDTH-2:0], bit_in};
                        rsp_valid_d = 1'b1;
                        rx_sr_d     = '0;
                        cnt_d       = '0;
                        state_d     = S_DONE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            cnt_q           <= '0;
            tx_sr_q         <= '0;
            rx_sr_q         <= '0;
            bit_out_q       <= 1'b0;
            bit_out_valid_q <= 1'b0;
            rsp_valid_q     <= 1'b0;
            rsp_word_q      <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            tx_sr_q         <= tx_sr_d;
            rx_sr_q         <= rx_sr_d;
            bit_out_q       <= bit_out_d;
            bit_out_valid_q <= bit_out_valid_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_word_q      <= rsp_word_d;
        end
    end

    assign req_ready     = (state_q == S_IDLE);
    assign busy          = (state_q != S_IDLE);
    assign bit_out       = bit_out_q;
    assign bit_out_valid = bit_out_valid_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_word      = rsp_word_q;

endmodule

// File: tb/tb_harness_serial_driver.sv
// Directed bench for harness_serial_driver: three instances (8/8 gap 2, 8/8 gap 0,
// default 166/327 gap 4) driven from a vector table plus hand-written corner sequences.
module tb_harness_serial_driver;

    logic clk;
    logic rst;

    logic       abort_a, req_valid_a, req_ready_a, bit_out_a, bit_out_valid_a, bit_in_a, rsp_valid_a, busy_a;
    logic [7:0] req_word_a, rsp_word_a;
    logic       abort_b, req_valid_b, req_ready_b, bit_out_b, bit_out_valid_b, bit_in_b, rsp_valid_b, busy_b;
    logic [7:0] req_word_b, rsp_word_b;
    logic         abort_c, req_valid_c, req_ready_c, bit_out_c, bit_out_valid_c, bit_in_c, rsp_valid_c, busy_c;
    logic [165:0] req_word_c;
    logic [326:0] rsp_word_c;

    int n_chk  = 0;
    int n_fail = 0;

    harness_serial_driver #(.TX_WIDTH(8), .RX_WIDTH(8), .GAP_CYCLES(2)) u_dut_a (
        .clk(clk), .rst(rst), .abort(abort_a), .req_valid(req_valid_a), .req_ready(req_ready_a),
        .req_word(req_word_a), .bit_out(bit_out_a), .bit_out_valid(bit_out_valid_a), .bit_in(bit_in_a),
        .rsp_valid(rsp_valid_a), .rsp_word(rsp_word_a), .busy(busy_a));

    harness_serial_driver #(.TX_WIDTH(8), .RX_WIDTH(8), .GAP_CYCLES(0)) u_dut_b (
        .clk(clk), .rst(rst), .abort(abort_b), .req_valid(req_valid_b), .req_ready(req_ready_b),
        .req_word(req_word_b), .bit_out(bit_out_b), .bit_out_valid(bit_out_valid_b), .bit_in(bit_in_b),
        .rsp_valid(rsp_valid_b), .rsp_word(rsp_word_b), .busy(busy_b));

    harness_serial_driver u_dut_c (
        .clk(clk), .rst(rst), .abort(abort_c), .req_valid(req_valid_c), .req_ready(req_ready_c),
        .req_word(req_word_c), .bit_out(bit_out_c), .bit_out_valid(bit_out_valid_c), .bit_in(bit_in_c),
        .rsp_valid(rsp_valid_c), .rsp_word(rsp_word_c), .busy(busy_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         sel;
        logic [7:0] tx;
        logic [7:0] rx;
    } vec_t;

    task automatic chk(input string nm, input logic [326:0] act, input logic [326:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Flags are packed as {bit_out, bit_out_valid, rsp_valid, busy, req_ready}.
    function automatic logic [4:0] flags_of(input int sel);
        case (sel)
            0: return {bit_out_a, bit_out_valid_a, rsp_valid_a, busy_a, req_ready_a};
            1: return {bit_out_b, bit_out_valid_b, rsp_valid_b, busy_b, req_ready_b};
            2: return {bit_out_c, bit_out_valid_c, rsp_valid_c, busy_c, req_ready_c};
            default: return 5'b0;
        endcase
    endfunction

    function automatic logic [326:0] rsp_of(input int sel);
        case (sel)
            0: return 327'(rsp_word_a);
            1: return 327'(rsp_word_b);
            2: return rsp_word_c;
            default: return '0;
        endcase
    endfunction

    task automatic set_req(input int sel, input logic v, input logic [165:0] w);
        case (sel)
            0: begin req_valid_a = v; req_word_a = w[7:0]; end
            1: begin req_valid_b = v; req_word_b = w[7:0]; end
            2: begin req_valid_c = v; req_word_c = w; end
            default: ;
        endcase
    endtask

    task automatic set_bin(input int sel, input logic b);
        case (sel)
            0: bit_in_a = b;
            1: bit_in_b = b;
            2: bit_in_c = b;
            default: ;
        endcase
    endtask

    // Independent model of the sect163k1 harness: done follows start, x echoes d, y is d rotated left.
    function automatic logic [326:0] harness_model(input logic [165:0] cmd);
        logic [162:0] d;
        d = cmd[162:0];
        return {cmd[163], d, d[161:0], d[162]};
    endfunction

    // Called one time unit after an edge; returns one time unit after the edge that leaves DONE.
    task automatic run_txn(input int sel, input logic [165:0] tx, input logic [326:0] rx,
                           input logic keep, input logic [165:0] nxt);
        int tw, rw, gp, lat, k, j;
        logic rb;
        logic [4:0] ef;
        tw  = (sel == 2) ? 166 : 8;
        rw  = (sel == 2) ? 327 : 8;
        gp  = (sel == 2) ? 4 : ((sel == 1) ? 0 : 2);
        lat = tw + gp + rw;
        set_req(sel, 1'b1, tx);
        set_bin(sel, 1'b1);
        rb = 1'b0;
        k  = 0;
        while (!rb && k < 40) begin
            rb = flags_of(sel)[0];
            @(posedge clk); #1;
            k++;
        end
        chk($sformatf("accept sel%0d", sel), 327'(rb), 327'(1));
        if (!rb) return;
        if (keep) set_req(sel, 1'b1, nxt);
        else      set_req(sel, 1'b0, '0);
        for (int n = 0; n <= lat + 1; n++) begin
            ef = {(n < tw) ? tx[tw-1-n] : 1'b0, (n < tw), (n == lat), (n <= lat), (n > lat)};
            chk($sformatf("flags sel%0d n%0d", sel, n), 327'(flags_of(sel)), 327'(ef));
            if (n == lat) chk($sformatf("rsp_word sel%0d", sel), rsp_of(sel), rx);
            j = n + 1 - (tw + gp + 1);
            set_bin(sel, (j >= 0 && j < rw) ? rx[rw-1-j] : 1'b1);
            if (n <= lat) begin
                @(posedge clk); #1;
            end
        end
    endtask

    vec_t         vt[5];
    logic [165:0] cmd;
    logic [326:0] exp_rsp;
    logic         seen;

    initial begin
        vt[0] = '{0, 8'hA5, 8'h3C};
        vt[1] = '{1, 8'h01, 8'h96};
        vt[2] = '{0, 8'h5A, 8'hC3};
        vt[3] = '{1, 8'h80, 8'h01};
        vt[4] = '{0, 8'hA5, 8'h3C};

        rst = 1'b1;
        abort_a = 1'b0; abort_b = 1'b0; abort_c = 1'b0;
        set_req(0, 1'b0, '0); set_req(1, 1'b0, '0); set_req(2, 1'b0, '0);
        set_bin(0, 1'b0); set_bin(1, 1'b0); set_bin(2, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            chk($sformatf("reset flags sel%0d", s), 327'(flags_of(s)), 327'(5'b00001));
            chk($sformatf("reset rsp sel%0d", s), rsp_of(s), '0);
        end
        #3 rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) run_txn(vt[i].sel, 166'(vt[i].tx), 327'(vt[i].rx), 1'b0, '0);

        // Abort must win over a handshake presented in the same cycle.
        set_req(0, 1'b1, 166'(8'h77));
        abort_a = 1'b1;
        @(posedge clk); #1;
        chk("abort vs handshake", 327'(flags_of(0)), 327'(5'b00001));
        abort_a = 1'b0;
        set_req(0, 1'b0, '0);

        // req_valid stays high: the second word may only be taken after DONE.
        run_txn(0, 166'(8'hFF), 327'(8'h81), 1'b1, 166'(8'h00));
        run_txn(0, 166'(8'h00), 327'(8'h3C), 1'b0, '0);

        // Abort after three RX samples (samples land on edges 11..13 after acceptance).
        set_req(0, 1'b1, 166'(8'h5A));
        @(posedge clk); #1;
        set_req(0, 1'b0, '0);
        repeat (13) begin
            @(posedge clk); #1;
        end
        abort_a = 1'b1;
        @(posedge clk); #1;
        abort_a = 1'b0;
        chk("abort flags", 327'(flags_of(0)), 327'(5'b00001));
        chk("abort rsp_word kept", rsp_of(0), 327'(8'h3C));
        seen = 1'b0;
        repeat (25) begin
            @(posedge clk); #1;
            if (rsp_valid_a) seen = 1'b1;
        end
        chk("no rsp_valid after abort", 327'(seen), '0);
        run_txn(0, 166'(8'h0F), 327'(8'hF0), 1'b0, '0);

        // Asynchronous reset mid-cycle during TX clears outputs before the next edge.
        set_req(0, 1'b1, 166'(8'hC3));
        @(posedge clk); #1;
        set_req(0, 1'b0, '0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        #3 rst = 1'b1;
        #1;
        chk("async rst flags", 327'(flags_of(0)), 327'(5'b00001));
        chk("async rst rsp_word", rsp_of(0), '0);
        #2 rst = 1'b0;
        @(posedge clk); #1;

        // Full-width transaction against the harness model.
        cmd[165] = 1'b1;
        cmd[164] = 1'b0;
        cmd[163] = 1'b1;
        for (int i = 0; i < 163; i++) cmd[i] = ((i % 3) == 0) || ((i % 11) == 4);
        exp_rsp = harness_model(cmd);
        run_txn(2, cmd, exp_rsp, 1'b0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
